// File: rtl/pipeline_if_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps one instruction-memory request
// in flight, and fills the IF/ID register, with a one-entry buffer for decode stalls.
module pipeline_if_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_IF,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction_ID,
   output logic [63:0] pc_ID,
   output logic        valid_ID
);

   localparam logic [1:0] ST_ISSUE = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_FULL  = 2'd3;

   logic [1:0]  state_reg, state_next;
   logic [63:0] fetch_pc_reg, fetch_pc_next;
   logic [31:0] buf_inst_reg, buf_inst_next;
   logic [63:0] buf_pc_reg, buf_pc_next;
   logic [31:0] inst_reg, inst_next;
   logic [63:0] pc_reg, pc_next;
   logic        valid_reg, valid_next;

   logic [63:0] target_pc;
   logic [63:0] pc_plus4;
   logic        slot_free;

   assign target_pc = redirect_pc & ~64'h3;
   assign pc_plus4  = fetch_pc_reg + 64'd4;
   assign slot_free = !valid_reg || !stall_IF;

   assign imem_req       = (state_reg == ST_ISSUE) && !redirect && !reset;
   assign imem_addr      = fetch_pc_reg;
   assign instruction_ID = inst_reg;
   assign pc_ID          = pc_reg;
   assign valid_ID       = valid_reg;

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      buf_inst_next = buf_inst_reg;
      buf_pc_next   = buf_pc_reg;
      pc_next       = pc_reg;
      // Without a load, a stalled decode keeps its instruction; otherwise it sees a bubble.
      if (stall_IF) begin
         inst_next  = inst_reg;
         valid_next = valid_reg;
      end else begin
         inst_next  = NOP_INST;
         valid_next = 1'b0;
      end

      case (state_reg)
         ST_ISSUE: begin
            if (redirect) begin
               fetch_pc_next = target_pc;
            end else begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               fetch_pc_next = target_pc;
               state_next    = imem_rvalid ? ST_ISSUE : ST_DRAIN;
            end else if (imem_rvalid) begin
               fetch_pc_next = pc_plus4;
               if (slot_free) begin
                  inst_next  = imem_rdata;
                  pc_next    = fetch_pc_reg;
                  valid_next = 1'b1;
                  state_next = ST_ISSUE;
               end else begin
                  buf_inst_next = imem_rdata;
                  buf_pc_next   = fetch_pc_reg;
                  state_next    = ST_FULL;
               end
            end
         end
         ST_DRAIN: begin
            // The stale response still owes us a strobe before a new request may go out.
            if (redirect) begin
               fetch_pc_next = target_pc;
            end
            if (imem_rvalid) begin
               state_next = ST_ISSUE;
            end
         end
         default: begin
            if (redirect) begin
               fetch_pc_next = target_pc;
               state_next    = ST_ISSUE;
            end else if (!stall_IF) begin
               inst_next  = buf_inst_reg;
               pc_next    = buf_pc_reg;
               valid_next = 1'b1;
               state_next = ST_ISSUE;
            end
         end
      endcase

      if (redirect) begin
         inst_next  = NOP_INST;
         valid_next = 1'b0;
         pc_next    = pc_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_ISSUE;
         fetch_pc_reg <= RESET_PC;
         buf_inst_reg <= 32'd0;
         buf_pc_reg   <= 64'd0;
         inst_reg     <= NOP_INST;
         pc_reg       <= 64'd0;
         valid_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         buf_inst_reg <= buf_inst_next;
         buf_pc_reg   <= buf_pc_next;
         inst_reg     <= inst_next;
         pc_reg       <= pc_next;
         valid_reg    <= valid_next;
      end
   end

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Scoreboard bench for pipeline_if_stage: expected requests and IF/ID instructions are
// queued by the directed stimulus and popped by the memory model and the ID-side monitor.
module tb_pipeline_if_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_IF;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction_ID;
   logic [63:0] pc_ID;
   logic        valid_ID;

   int          errors = 0;
   int          checks = 0;
   int          lat = 1;
   exp_t        exp_q[$];
   logic [63:0] exp_req[$];

   pipeline_if_stage #(.RESET_PC(64'h1000), .NOP_INST(NOP)) dut (
      .clk(clk), .reset(reset), .stall_IF(stall_IF), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instruction_ID(instruction_ID), .pc_ID(pc_ID), .valid_ID(valid_ID)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic push_id(input logic [63:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      exp_q.push_back(e);
   endtask

   // Memory model: each request is checked against the expected-address queue and
   // answered lat cycles later with {16'hC0DE, addr[15:0]}.
   initial begin
      logic        pending;
      int          rem;
      logic [63:0] paddr;
      logic [63:0] want;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      pending     = 1'b0;
      rem         = 0;
      paddr       = 64'd0;
      forever begin
         @(posedge clk);
         if (imem_req === 1'b1) begin
            if (exp_req.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL req_unexpected: got request at %h, expected none", imem_addr);
            end else begin
               want = exp_req.pop_front();
               chk("req_addr", imem_addr, want);
               $display("REQ addr=%h", imem_addr);
            end
            pending = 1'b1;
            rem     = lat;
            paddr   = imem_addr;
         end
         #1;
         if (pending) begin
            if (rem <= 1) begin
               imem_rvalid = 1'b1;
               imem_rdata  = {16'hC0DE, paddr[15:0]};
               pending     = 1'b0;
            end else begin
               rem--;
               imem_rvalid = 1'b0;
            end
         end else begin
            imem_rvalid = 1'b0;
         end
      end
   end

   // Decode-side monitor: an instruction is consumed when valid and not stalled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid_ID === 1'b1 && stall_IF === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL id_unexpected: got pc %h inst %h, expected none", pc_ID, instruction_ID);
            end else begin
               e = exp_q.pop_front();
               chk("id_pc", pc_ID, e.pc);
               chk("id_inst", {32'd0, instruction_ID}, {32'd0, e.inst});
               $display("ID  pc=%h inst=%h", pc_ID, instruction_ID);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; stall_IF = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
      tick(); tick(); neg();
      chk("rst_req", {63'd0, imem_req}, 64'd0);
      chk("rst_valid", {63'd0, valid_ID}, 64'd0);
      chk("rst_inst", {32'd0, instruction_ID}, {32'd0, NOP});
      chk("rst_pc", pc_ID, 64'd0);
      exp_req.push_back(64'h1000); exp_req.push_back(64'h1004); exp_req.push_back(64'h1008);
      exp_req.push_back(64'h100C); exp_req.push_back(64'h1010);
      push_id(64'h1000, 32'hC0DE1000); push_id(64'h1004, 32'hC0DE1004); push_id(64'h1008, 32'hC0DE1008);

      // Streaming with L=1, then a 5-cycle stall that parks the next response in the buffer.
      tick(); reset = 1'b0;
      repeat (6) tick();
      stall_IF = 1'b1;
      tick(); tick();
      repeat (3) begin
         neg();
         chk("full_no_req", {63'd0, imem_req}, 64'd0);
         chk("full_hold_valid", {63'd0, valid_ID}, 64'd1);
         chk("full_hold_pc", pc_ID, 64'h1008);
         chk("full_hold_inst", {32'd0, instruction_ID}, 64'hC0DE1008);
         tick();
      end
      stall_IF = 1'b0;
      tick(); stall_IF = 1'b1;
      neg();
      chk("buf_out_valid", {63'd0, valid_ID}, 64'd1);
      chk("buf_out_pc", pc_ID, 64'h100C);
      chk("buf_out_inst", {32'd0, instruction_ID}, 64'hC0DE100C);

      // Redirect out of FULL while stalled, then redirect in WAIT with a late stale response.
      tick(); tick();
      redirect = 1'b1; redirect_pc = 64'h3000; lat = 3; exp_req.push_back(64'h3000);
      neg();
      chk("redir_full_no_req", {63'd0, imem_req}, 64'd0);
      tick(); redirect = 1'b0; stall_IF = 1'b0;
      neg();
      chk("redir_full_valid", {63'd0, valid_ID}, 64'd0);
      chk("redir_full_inst", {32'd0, instruction_ID}, {32'd0, NOP});
      chk("redir_full_pc_held", pc_ID, 64'h100C);
      tick(); redirect = 1'b1; redirect_pc = 64'h2002;
      exp_req.push_back(64'h2000); exp_req.push_back(64'h2004); push_id(64'h2000, 32'hC0DE2000);
      neg();
      chk("redir_wait_no_req", {63'd0, imem_req}, 64'd0);
      tick(); redirect = 1'b0; lat = 1;
      repeat (4) begin
         neg();
         chk("drain_bubble", {63'd0, valid_ID}, 64'd0);
         tick();
      end

      // Redirect coincident with a response while stalled.
      tick();
      stall_IF = 1'b1; redirect = 1'b1; redirect_pc = 64'h4000;
      exp_req.push_back(64'h4000); push_id(64'h4000, 32'hC0DE4000);
      neg();
      chk("redir_rv_no_req", {63'd0, imem_req}, 64'd0);
      tick(); redirect = 1'b0; stall_IF = 1'b0;
      neg();
      chk("redir_rv_valid", {63'd0, valid_ID}, 64'd0);
      chk("redir_rv_inst", {32'd0, instruction_ID}, {32'd0, NOP});
      chk("redir_rv_req", {63'd0, imem_req}, 64'd1);
      chk("redir_rv_addr", imem_addr, 64'h4000);

      // Fetch PC wraparound at the top of the address space.
      tick(); tick();
      redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_req.push_back(64'h0); exp_req.push_back(64'h4);
      push_id(64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DEFFFC);
      neg();
      chk("redir_issue_no_req", {63'd0, imem_req}, 64'd0);
      tick(); redirect = 1'b0;
      tick(); tick();
      neg();
      chk("wrap_pc", pc_ID, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_valid", {63'd0, valid_ID}, 64'd1);
      chk("wrap_req", {63'd0, imem_req}, 64'd1);
      chk("wrap_addr", imem_addr, 64'h0);
      tick(); tick(); stall_IF = 1'b1;
      neg();
      chk("zero_pc", pc_ID, 64'h0);
      chk("zero_inst", {32'd0, instruction_ID}, 64'hC0DE0000);

      // Reset while parked in FULL.
      tick(); tick();
      reset = 1'b1; exp_req.push_back(64'h1000); push_id(64'h1000, 32'hC0DE1000);
      neg();
      chk("prerst_valid", {63'd0, valid_ID}, 64'd1);
      chk("rst_full_no_req", {63'd0, imem_req}, 64'd0);
      tick(); reset = 1'b0; stall_IF = 1'b0;
      neg();
      chk("rst2_valid", {63'd0, valid_ID}, 64'd0);
      chk("rst2_inst", {32'd0, instruction_ID}, {32'd0, NOP});
      chk("rst2_pc", pc_ID, 64'h0);
      chk("rst2_req", {63'd0, imem_req}, 64'd1);
      chk("rst2_addr", imem_addr, 64'h1000);
      tick(); tick();
      neg();
      #1;
      chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
      chk("id_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_if_stage.md
# pipeline_if_stage

Instruction fetch stage of the 5-stage RV64 pipeline: the producer side of the IF/ID interface that the decode stage consumes (`instruction_ID`, `pc_ID`). It owns the fetch PC, issues single-outstanding requests to instruction memory, and registers the returned instruction with its PC into the IF/ID pipeline register. It honours decode-stage stalls through a one-entry buffer and discards in-flight fetches on a branch/jump redirect.

## Interface
- `RESET_PC`, 64'h0, fetch PC loaded on reset
- `NOP_INST`, 32'h00000013, instruction driven on `instruction_ID` for bubbles (addi x0,x0,0)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall_IF`  in  1  hazard unit: hold the IF/ID register this cycle
- `redirect`  in  1  taken branch/jump from EX: flush and refetch
- `redirect_pc`  in  64  redirect target; bits [1:0] forced to 0
- `imem_req`  out  1  one-cycle fetch request pulse
- `imem_addr`  out  64  fetch address, valid when `imem_req`=1
- `imem_rvalid`  in  1  response strobe, ≥1 cycle after request
- `imem_rdata`  in  32  instruction, valid when `imem_rvalid`=1
- `instruction_ID`  out  32  IF/ID instruction register
- `pc_ID`  out  64  IF/ID PC register (address of `instruction_ID`)
- `valid_ID`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Registers: `fetch_pc` (64), `state`, `buf_inst` (32), `buf_pc` (64), IF/ID outputs.
- Memory protocol: at most one request outstanding; memory always accepts; exactly one `imem_rvalid` per request. `imem_req` = (state==ISSUE) & !redirect & !reset; `imem_addr` = `fetch_pc`.
- Output slot "free" = !valid_ID | !stall_IF.
- States:
  - ISSUE: request at `fetch_pc` → WAIT. If `redirect`: no request, `fetch_pc`←redirect_pc, stay.
  - WAIT: `imem_rvalid` & !redirect & slot free → output←(rdata, fetch_pc, valid 1), `fetch_pc`+=4, → ISSUE. `imem_rvalid` & !redirect & slot not free → buf←(rdata, fetch_pc), `fetch_pc`+=4, → FULL. `redirect` & `imem_rvalid` → response dropped, `fetch_pc`←redirect_pc, → ISSUE. `redirect` & !`imem_rvalid` → `fetch_pc`←redirect_pc, → DRAIN.
  - DRAIN: wait for stale response; `imem_rvalid` → discard, → ISSUE. `redirect` here updates `fetch_pc` again, stays DRAIN.
  - FULL: no requests. `stall_IF`=0 → output←buf (valid 1), → ISSUE. `redirect` → buf dropped, `fetch_pc`←redirect_pc, → ISSUE.
- IF/ID register rules, priority order: reset; redirect → valid_ID=0, instruction_ID=NOP_INST (pc_ID unchanged); stall_IF → hold all three; load from rdata/buf as above; otherwise bubble (valid_ID=0, instruction_ID=NOP_INST, pc_ID held).
- Redirect overrides stall_IF in every state.
- `fetch_pc` increments modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC + 4 → 0).

## Timing
- Reset (sync): state=ISSUE, fetch_pc=RESET_PC, instruction_ID=NOP_INST, pc_ID=0, valid_ID=0, buf cleared, imem_req=0 during reset cycle.
- First request in the first cycle after reset deasserts.
- Latency: request cycle N, rvalid at N+L → valid_ID=1 from edge ending cycle N+L; next request at N+L+1. Peak throughput 1 instruction / (L+1) cycles.
- Redirect asserted in cycle R: IF/ID bubbled after edge R; target request in R+1 (ISSUE/WAIT-with-rvalid/FULL), or the cycle after the stale response arrives (DRAIN).
- Reset mid-WAIT/DRAIN: state cleared; a late `imem_rvalid` while in ISSUE is ignored (environment must not reset memory mid-transaction otherwise).
- No combinational path from `imem_rdata` to outputs; `imem_req` depends combinationally on `redirect`.

## Test plan
- Reset, RESET_PC=0x1000, memory L=1 → requests at 0x1000,0x1004,0x1008 every 2 cycles; pc_ID/instruction_ID match, valid_ID=1 one cycle per instruction, bubbles between.
- stall_IF=1 held 5 cycles while valid_ID=1 and response arrives → state FULL, no new imem_req, outputs unchanged; release → buffered instruction appears next edge with correct pc.
- redirect to 0x2002 in WAIT without rvalid, rvalid 2 cycles later → stale data never appears (valid_ID=0), next request at 0x2000.
- redirect coincident with imem_rvalid and stall_IF=1 → response dropped, valid_ID=0, request at target next cycle.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC → pc_ID equals it, next imem_addr=0.
- reset asserted in FULL → all outputs return to reset values, next request at RESET_PC.
